// File: rtl/rv32im_interrupt_controller.sv
// Edge-triggered interrupt controller with lowest-index priority, one-deep service
// FSM and a Wishbone-style register window (ENABLE, PENDING, STATUS).
module rv32im_interrupt_controller #(
  parameter int XLEN         = 32,
  parameter int INT_VECT_LEN = 8
) (
  input  logic                    clk_i,
  input  logic                    reset_ni,
  input  logic [INT_VECT_LEN-1:0] irq_i,
  output logic                    interrupt_trigger_o,
  output logic [XLEN-1:0]         interrupt_vector_offset_o,
  input  logic                    interrupt_routine_complete_i,
  input  logic [1:0]              adr_i,
  input  logic [XLEN-1:0]         dat_i,
  output logic [XLEN-1:0]         dat_o,
  input  logic                    stb_i,
  input  logic                    we_i,
  output logic                    ack_o
);

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    SERVICE = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [INT_VECT_LEN-1:0] irq_prev_q;
  logic [INT_VECT_LEN-1:0] enable_q, enable_d;
  logic [INT_VECT_LEN-1:0] pending_q, pending_d;
  logic                    trigger_q, trigger_d;
  logic [XLEN-1:0]         offset_q, offset_d;
  logic [4:0]              last_idx_q, last_idx_d;
  logic                    ack_q, ack_d;
  logic [XLEN-1:0]         dat_q, dat_d;

  logic [INT_VECT_LEN-1:0] edge_s;
  logic [INT_VECT_LEN-1:0] req_s;
  logic [INT_VECT_LEN-1:0] sel_onehot_s;
  logic [INT_VECT_LEN-1:0] disp_clr_s;
  logic [INT_VECT_LEN-1:0] w1c_s;
  logic [4:0]              sel_idx_s;
  logic                    found_s;
  logic [XLEN-1:0]         offset_calc_s;
  logic                    bus_req_s;
  logic                    bus_wr_s;
  logic [XLEN-1:0]         rdata_s;

  // Only the low INT_VECT_LEN bits of write data reach a register.
  if (XLEN > INT_VECT_LEN) begin : g_unused
    logic unused_dat_s;
    assign unused_dat_s = ^dat_i[XLEN-1:INT_VECT_LEN];
  end

  // Edge detection, request masking and lowest-index priority select.
  always_comb begin
    edge_s       = irq_i & ~irq_prev_q;
    req_s        = pending_q & enable_q;
    sel_onehot_s = '0;
    sel_idx_s    = 5'd0;
    found_s      = 1'b0;
    for (int i = 0; i < INT_VECT_LEN; i++) begin
      if (req_s[i] && !found_s) begin
        sel_onehot_s[i] = 1'b1;
        sel_idx_s       = 5'(i);
        found_s         = 1'b1;
      end else begin
        sel_onehot_s[i] = 1'b0;
      end
    end
    offset_calc_s      = '0;
    offset_calc_s[6:2] = sel_idx_s;
  end

  // Dispatch / service FSM next state.
  always_comb begin
    state_d    = state_q;
    trigger_d  = 1'b0;
    offset_d   = offset_q;
    last_idx_d = last_idx_q;
    disp_clr_s = '0;
    case (state_q)
      IDLE: begin
        if (found_s) begin
          state_d    = SERVICE;
          trigger_d  = 1'b1;
          offset_d   = offset_calc_s;
          last_idx_d = sel_idx_s;
          disp_clr_s = sel_onehot_s;
        end else begin
          state_d = IDLE;
        end
      end
      SERVICE: begin
        if (interrupt_routine_complete_i) begin
          state_d = IDLE;
        end else begin
          state_d = SERVICE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Bus decode: a strobe is accepted only while no ack is outstanding.
  always_comb begin
    bus_req_s = stb_i & ~ack_q;
    bus_wr_s  = bus_req_s & we_i;
    enable_d  = enable_q;
    w1c_s     = '0;
    if (bus_wr_s) begin
      case (adr_i)
        2'd0: enable_d = dat_i[INT_VECT_LEN-1:0];
        2'd1: w1c_s = dat_i[INT_VECT_LEN-1:0];
        default: begin
          enable_d = enable_q;
          w1c_s    = '0;
        end
      endcase
    end else begin
      enable_d = enable_q;
      w1c_s    = '0;
    end
    // New edges are ORed in last so a set always beats a same-cycle clear.
    pending_d = (pending_q & ~disp_clr_s & ~w1c_s) | edge_s;
  end

  // Register read mux and registered bus response.
  always_comb begin
    rdata_s = '0;
    case (adr_i)
      2'd0: rdata_s[INT_VECT_LEN-1:0] = enable_q;
      2'd1: rdata_s[INT_VECT_LEN-1:0] = pending_q;
      2'd2: begin
        rdata_s[0]    = (state_q == SERVICE);
        rdata_s[12:8] = last_idx_q;
      end
      default: rdata_s = '0;
    endcase
    ack_d = bus_req_s;
    if (bus_req_s) begin
      dat_d = rdata_s;
    end else begin
      dat_d = '0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q    <= IDLE;
      irq_prev_q <= '0;
      enable_q   <= '0;
      pending_q  <= '0;
      trigger_q  <= 1'b0;
      offset_q   <= '0;
      last_idx_q <= 5'd0;
      ack_q      <= 1'b0;
      dat_q      <= '0;
    end else begin
      state_q    <= state_d;
      irq_prev_q <= irq_i;
      enable_q   <= enable_d;
      pending_q  <= pending_d;
      trigger_q  <= trigger_d;
      offset_q   <= offset_d;
      last_idx_q <= last_idx_d;
      ack_q      <= ack_d;
      dat_q      <= dat_d;
    end
  end

  assign interrupt_trigger_o       = trigger_q;
  assign interrupt_vector_offset_o = offset_q;
  assign ack_o                     = ack_q;
  assign dat_o                     = dat_q;

endmodule

// File: tb/tb_rv32im_interrupt_controller.sv
// Randomized and directed bench for rv32im_interrupt_controller against a cycle-level
// behavioural model of the controller's rules.
module tb_rv32im_interrupt_controller;

  logic        clk = 1'b0;
  logic        reset_ni;
  logic [7:0]  irq_i;
  logic        interrupt_trigger_o;
  logic [31:0] interrupt_vector_offset_o;
  logic        interrupt_routine_complete_i;
  logic [1:0]  adr_i;
  logic [31:0] dat_i;
  logic [31:0] dat_o;
  logic        stb_i;
  logic        we_i;
  logic        ack_o;

  int errors = 0;
  int checks = 0;

  // Model state
  bit [7:0]  m_prev, m_en, m_pend;
  bit        m_serv, m_trig, m_ack;
  int        m_last;
  bit [31:0] m_off, m_dat;

  always #5 clk = ~clk;

  rv32im_interrupt_controller #(.XLEN(32), .INT_VECT_LEN(8)) dut (
    .clk_i                        (clk),
    .reset_ni                     (reset_ni),
    .irq_i                        (irq_i),
    .interrupt_trigger_o          (interrupt_trigger_o),
    .interrupt_vector_offset_o    (interrupt_vector_offset_o),
    .interrupt_routine_complete_i (interrupt_routine_complete_i),
    .adr_i                        (adr_i),
    .dat_i                        (dat_i),
    .dat_o                        (dat_o),
    .stb_i                        (stb_i),
    .we_i                         (we_i),
    .ack_o                        (ack_o)
  );

  task automatic model_reset();
    m_prev = 8'd0; m_en = 8'd0; m_pend = 8'd0;
    m_serv = 1'b0; m_trig = 1'b0; m_ack = 1'b0;
    m_last = 0; m_off = 32'd0; m_dat = 32'd0;
  endtask

  // One clock edge of the controller, described by its rules.
  task automatic model_step(input bit [7:0] irq, input bit cpl, input bit stb,
                            input bit we, input bit [1:0] adr, input bit [31:0] dat);
    bit [7:0] edges, ready, pn;
    bit       bus;
    int       k;
    edges = irq & ~m_prev;
    bus   = stb && !m_ack;
    ready = m_pend & m_en;
    k = -1;
    if (!m_serv) begin
      for (int i = 7; i >= 0; i--) if (ready[i]) k = i;
    end
    m_dat = 32'd0;
    if (bus) begin
      case (adr)
        2'd0: m_dat = {24'd0, m_en};
        2'd1: m_dat = {24'd0, m_pend};
        2'd2: m_dat = (32'(m_last) << 8) | {31'd0, m_serv};
        default: m_dat = 32'd0;
      endcase
    end
    pn = m_pend;
    if (k >= 0) pn[k] = 1'b0;
    if (bus && we && adr == 2'd1) pn = pn & ~dat[7:0];
    pn = pn | edges;
    if (bus && we && adr == 2'd0) m_en = dat[7:0];
    m_trig = (k >= 0);
    if (k >= 0) begin
      m_off  = 32'(k * 4);
      m_last = k;
      m_serv = 1'b1;
    end else if (m_serv && cpl) begin
      m_serv = 1'b0;
    end
    m_pend = pn;
    m_ack  = bus;
    m_prev = irq;
  endtask

  // Drive one cycle of inputs, clock, advance the model, settle.
  task automatic cyc(input bit [7:0] irq, input bit cpl, input bit stb,
                     input bit we, input bit [1:0] adr, input bit [31:0] dat);
    irq_i = irq; interrupt_routine_complete_i = cpl;
    stb_i = stb; we_i = we; adr_i = adr; dat_i = dat;
    @(posedge clk);
    model_step(irq, cpl, stb, we, adr, dat);
    #1;
  endtask

  task automatic bus_rd(input bit [1:0] a, input bit [7:0] irq,
                        output bit [31:0] d, output bit ak);
    cyc(irq, 1'b0, 1'b1, 1'b0, a, 32'd0);
    d  = dat_o;
    ak = ack_o;
    cyc(irq, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0);
  endtask

  task automatic bus_wr(input bit [1:0] a, input bit [31:0] d, input bit [7:0] irq,
                        output bit ak);
    cyc(irq, 1'b0, 1'b1, 1'b1, a, d);
    ak = ack_o;
    cyc(irq, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0);
  endtask

  task automatic test_reset();
    bit [31:0] d;
    bit        ak;
    reset_ni = 1'b0;
    irq_i = 8'd0; interrupt_routine_complete_i = 1'b0;
    stb_i = 1'b0; we_i = 1'b0; adr_i = 2'd0; dat_i = 32'd0;
    model_reset();
    #12;
    checks++; if (interrupt_trigger_o !== 1'b0) begin errors++; $display("FAIL reset_trig got=%0b exp=0", interrupt_trigger_o); end
    checks++; if (interrupt_vector_offset_o !== 32'd0) begin errors++; $display("FAIL reset_offset got=%0h exp=0", interrupt_vector_offset_o); end
    checks++; if (ack_o !== 1'b0) begin errors++; $display("FAIL reset_ack got=%0b exp=0", ack_o); end
    checks++; if (dat_o !== 32'd0) begin errors++; $display("FAIL reset_dat got=%0h exp=0", dat_o); end
    @(posedge clk); #1;
    reset_ni = 1'b1;
    bus_wr(2'd3, 32'hFFFF_FFFF, 8'd0, ak);
    for (int a = 0; a < 4; a++) begin
      bus_rd(2'(a), 8'd0, d, ak);
      checks++; if (ak !== 1'b1) begin errors++; $display("FAIL reset_rd_ack adr=%0d got=%0b exp=1", a, ak); end
      checks++; if (d !== 32'd0) begin errors++; $display("FAIL reset_rd adr=%0d got=%0h exp=0", a, d); end
    end
  endtask

  task automatic test_dispatch();
    bit [31:0] d;
    bit        ak;
    bus_wr(2'd0, 32'h5, 8'd0, ak);
    checks++; if (ak !== 1'b1) begin errors++; $display("FAIL wr_ack got=%0b exp=1", ak); end
    cyc(8'h04, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0);
    checks++; if (interrupt_trigger_o !== 1'b0) begin errors++; $display("FAIL disp_early got=%0b exp=0", interrupt_trigger_o); end
    cyc(8'h00, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0);
    checks++; if (interrupt_trigger_o !== 1'b1) begin errors++; $display("FAIL disp_trig got=%0b exp=1", interrupt_trigger_o); end
    checks++; if (interrupt_vector_offset_o !== 32'h8) begin errors++; $display("FAIL disp_off got=%0h exp=8", interrupt_vector_offset_o); end
    cyc(8'h00, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0);
    checks++; if (interrupt_trigger_o !== 1'b0) begin errors++; $display("FAIL disp_width got=%0b exp=0", interrupt_trigger_o); end
    checks++; if (interrupt_vector_offset_o !== 32'h8) begin errors++; $display("FAIL disp_hold got=%0h exp=8", interrupt_vector_offset_o); end
    bus_rd(2'd2, 8'd0, d, ak);
    checks++; if (d !== 32'h201) begin errors++; $display("FAIL status_serv got=%0h exp=201", d); end
    bus_rd(2'd1, 8'd0, d, ak);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL pend_cleared got=%0h exp=0", d); end
    cyc(8'h00, 1'b1, 1'b0, 1'b0, 2'd0, 32'd0);
    bus_rd(2'd2, 8'd0, d, ak);
    checks++; if (d !== 32'h200) begin errors++; $display("FAIL status_idle got=%0h exp=200", d); end
  endtask

  task automatic test_priority();
    bit [31:0] d;
    bit        ak;
    cyc(8'h05, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0);
    cyc(8'h00, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0);
    checks++; if (interrupt_trigger_o !== 1'b1) begin errors++; $display("FAIL prio_trig0 got=%0b exp=1", interrupt_trigger_o); end
    checks++; if (interrupt_vector_offset_o !== 32'h0) begin errors++; $display("FAIL prio_off0 got=%0h exp=0", interrupt_vector_offset_o); end
    for (int i = 0; i < 3; i++) begin
      cyc(8'h00, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0);
      checks++; if (interrupt_trigger_o !== 1'b0) begin errors++; $display("FAIL prio_serv_hold i=%0d got=%0b exp=0", i, interrupt_trigger_o); end
    end
    bus_rd(2'd1, 8'd0, d, ak);
    checks++; if (d !== 32'h4) begin errors++; $display("FAIL prio_pend got=%0h exp=4", d); end
    cyc(8'h00, 1'b1, 1'b0, 1'b0, 2'd0, 32'd0);
    checks++; if (interrupt_trigger_o !== 1'b0) begin errors++; $display("FAIL prio_cpl got=%0b exp=0", interrupt_trigger_o); end
    cyc(8'h00, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0);
    checks++; if (interrupt_trigger_o !== 1'b1) begin errors++; $display("FAIL prio_trig2 got=%0b exp=1", interrupt_trigger_o); end
    checks++; if (interrupt_vector_offset_o !== 32'h8) begin errors++; $display("FAIL prio_off2 got=%0h exp=8", interrupt_vector_offset_o); end
    cyc(8'h00, 1'b1, 1'b0, 1'b0, 2'd0, 32'd0);
  endtask

  task automatic test_masked();
    bit [31:0] d;
    bit        ak;
    bus_wr(2'd0, 32'h0, 8'd0, ak);
    cyc(8'h02, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      cyc(8'h00, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0);
      checks++; if (interrupt_trigger_o !== 1'b0) begin errors++; $display("FAIL mask_notrig i=%0d got=%0b exp=0", i, interrupt_trigger_o); end
    end
    bus_rd(2'd1, 8'd0, d, ak);
    checks++; if (d !== 32'h2) begin errors++; $display("FAIL mask_pend got=%0h exp=2", d); end
    bus_wr(2'd0, 32'h2, 8'd0, ak);
    checks++; if (interrupt_trigger_o !== 1'b1) begin errors++; $display("FAIL mask_trig got=%0b exp=1", interrupt_trigger_o); end
    checks++; if (interrupt_vector_offset_o !== 32'h4) begin errors++; $display("FAIL mask_off got=%0h exp=4", interrupt_vector_offset_o); end
    cyc(8'h00, 1'b1, 1'b0, 1'b0, 2'd0, 32'd0);
  endtask

  task automatic test_w1c_race();
    bit [31:0] d;
    bit        ak;
    bus_wr(2'd0, 32'h0, 8'd0, ak);
    cyc(8'h02, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0);
    cyc(8'h00, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0);
    cyc(8'h02, 1'b0, 1'b1, 1'b1, 2'd1, 32'h2);
    cyc(8'h02, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0);
    bus_rd(2'd1, 8'h02, d, ak);
    checks++; if (d !== 32'h2) begin errors++; $display("FAIL w1c_race got=%0h exp=2", d); end
    cyc(8'h00, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0);
    bus_wr(2'd1, 32'h2, 8'd0, ak);
    bus_rd(2'd1, 8'd0, d, ak);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL w1c_clear got=%0h exp=0", d); end
  endtask

  task automatic test_back_to_back();
    bit ak;
    bit exp_ack;
    bus_wr(2'd0, 32'hA0, 8'd0, ak);
    for (int i = 0; i < 4; i++) begin
      cyc(8'h00, 1'b0, 1'b1, 1'b0, 2'd0, 32'd0);
      exp_ack = (i % 2 == 0);
      checks++; if (ack_o !== exp_ack) begin errors++; $display("FAIL b2b_ack i=%0d got=%0b exp=%0b", i, ack_o, exp_ack); end
      if (exp_ack) begin
        checks++; if (dat_o !== 32'hA0) begin errors++; $display("FAIL b2b_dat i=%0d got=%0h exp=a0", i, dat_o); end
      end
    end
    cyc(8'h00, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0);
  endtask

  task automatic test_random();
    bit [7:0]  r_irq;
    bit        r_cpl, r_stb, r_we;
    bit [1:0]  r_adr;
    bit [31:0] r_dat;
    r_irq = 8'd0;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 2) == 0) r_irq = 8'($urandom_range(0, 255));
      r_cpl = ($urandom_range(0, 5) == 0);
      r_stb = ($urandom_range(0, 2) == 0);
      r_we  = 1'($urandom_range(0, 1));
      r_adr = 2'($urandom_range(0, 3));
      r_dat = $urandom();
      cyc(r_irq, r_cpl, r_stb, r_we, r_adr, r_dat);
      checks++; if (interrupt_trigger_o !== m_trig) begin errors++; $display("FAIL rand_trig n=%0d got=%0b exp=%0b", n, interrupt_trigger_o, m_trig); end
      checks++; if (interrupt_vector_offset_o !== m_off) begin errors++; $display("FAIL rand_off n=%0d got=%0h exp=%0h", n, interrupt_vector_offset_o, m_off); end
      checks++; if (ack_o !== m_ack) begin errors++; $display("FAIL rand_ack n=%0d got=%0b exp=%0b", n, ack_o, m_ack); end
      if (m_ack) begin
        checks++; if (dat_o !== m_dat) begin errors++; $display("FAIL rand_dat n=%0d got=%0h exp=%0h", n, dat_o, m_dat); end
      end
    end
  endtask

  task automatic test_reset_service();
    bit [31:0] d;
    bit        ak;
    reset_ni = 1'b0;
    model_reset();
    @(posedge clk); #1;
    reset_ni = 1'b1;
    bus_wr(2'd0, 32'h3, 8'd0, ak);
    cyc(8'h01, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0);
    cyc(8'h00, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0);
    cyc(8'h03, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0);
    cyc(8'h00, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0);
    bus_rd(2'd1, 8'd0, d, ak);
    checks++; if (d !== 32'h3) begin errors++; $display("FAIL rs_pend_pre got=%0h exp=3", d); end
    bus_rd(2'd2, 8'd0, d, ak);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL rs_status_pre got=%0h exp=1", d); end
    // Open a bus write, then reset before the edge that would ack it.
    stb_i = 1'b1; we_i = 1'b1; adr_i = 2'd0; dat_i = 32'hFF;
    #2;
    reset_ni = 1'b0;
    model_reset();
    #1;
    checks++; if (ack_o !== 1'b0) begin errors++; $display("FAIL rs_ack_async got=%0b exp=0", ack_o); end
    @(posedge clk); #1;
    checks++; if (ack_o !== 1'b0) begin errors++; $display("FAIL rs_ack_held got=%0b exp=0", ack_o); end
    stb_i = 1'b0; we_i = 1'b0;
    reset_ni = 1'b1;
    cyc(8'h00, 1'b1, 1'b0, 1'b0, 2'd0, 32'd0);
    checks++; if (interrupt_trigger_o !== 1'b0) begin errors++; $display("FAIL rs_cpl_trig got=%0b exp=0", interrupt_trigger_o); end
    cyc(8'h00, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0);
    checks++; if (interrupt_trigger_o !== 1'b0) begin errors++; $display("FAIL rs_trig got=%0b exp=0", interrupt_trigger_o); end
    checks++; if (interrupt_vector_offset_o !== 32'd0) begin errors++; $display("FAIL rs_off got=%0h exp=0", interrupt_vector_offset_o); end
    for (int a = 0; a < 3; a++) begin
      bus_rd(2'(a), 8'd0, d, ak);
      checks++; if (d !== 32'd0) begin errors++; $display("FAIL rs_reg adr=%0d got=%0h exp=0", a, d); end
    end
    // A source held high through reset release counts as a fresh edge.
    irq_i = 8'h01;
    reset_ni = 1'b0;
    model_reset();
    @(posedge clk); #1;
    reset_ni = 1'b1;
    cyc(8'h01, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0);
    bus_rd(2'd1, 8'h01, d, ak);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL rs_held_edge got=%0h exp=1", d); end
  endtask

  initial begin
    test_reset();
    test_dispatch();
    test_priority();
    test_masked();
    test_w1c_race();
    test_back_to_back();
    test_random();
    test_reset_service();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
